bsg_dfi_cmd_decoder: RTL

- Sits directly downstream of the DFI-to-FIFO bridge, in the FIFO clock domain.
- Consumes the packed DFI command stream and the write-data stream, and decodes DDR3 commands.
- Tracks the open row in each of the 8 banks and emits decoded read/write memory requests to the off-chip link.
- Buffers returned read beats and presents them back on the bridge's read-data interface.

---
 rtl/bsg_dfi_pkg.sv | 47 ++++
 rtl/bsg_dfi_bank_tracker.sv | 36 +++
 rtl/bsg_fifo_1r1w_small.sv | 49 ++++
 rtl/bsg_dfi_cmd_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bsg_dfi_pkg.sv
// Shared types for the DFI command decoder: packed command layout,
// DDR3 command enum, decode helper and memory-request header.
package bsg_dfi_pkg;

    typedef struct packed {
        logic [2:0]  bank;
        logic [15:0] addr;
        logic        cke;
        logic        cs_n;
        logic        ras_n;
        logic        cas_n;
        logic        we_n;
        logic        reset_n;
        logic        odt;
    } bsg_dfi_cmd_s;

    typedef enum logic [2:0] {
        ACT, RD, WR, PRE, REF, MRS, ZQ, NOP
    } bsg_ddr_cmd_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } bsg_dfi_mem_hdr_s;

    // key = {cs_n, ras_n, cas_n, we_n}; deselected commands fold into NOP
    function automatic bsg_ddr_cmd_e bsg_ddr_decode(input logic [3:0] key);
        bsg_ddr_cmd_e c;
        c = NOP;
        unique case (1'b1)
            key[3]:           c = NOP;
            key == 4'b0011:   c = ACT;
            key == 4'b0010:   c = PRE;
            key == 4'b0101:   c = RD;
            key == 4'b0100:   c = WR;
            key == 4'b0001:   c = REF;
            key == 4'b0000:   c = MRS;
            key == 4'b0110:   c = ZQ;
            key == 4'b0111:   c = NOP;
            default:          c = NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bsg_dfi_bank_tracker.sv
// Per-bank open flag and active row, updated by ACT/PRE, flags misuse.
module bsg_dfi_bank_tracker
    import bsg_dfi_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         v_i,
    input  bsg_ddr_cmd_e cmd_i,
    input  logic [2:0]   bank_i,
    input  logic [15:0]  addr_i,
    output logic [15:0]  row_o,
    output logic         err_o
);
    logic [7:0]  open_r;
    logic [15:0] row_r [8];

    assign row_o = row_r[bank_i];
    assign err_o = v_i & (((cmd_i == ACT) & open_r[bank_i])
                 | (((cmd_i == RD) | (cmd_i == WR)) & ~open_r[bank_i]));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            open_r <= '0;
            for (int i = 0; i < 8; i++) row_r[i] <= '0;
        end else if (v_i) begin
            if (cmd_i == ACT) begin
                open_r[bank_i] <= 1'b1;
                row_r[bank_i]  <= addr_i;
            end else if (cmd_i == PRE) begin
                if (addr_i[10]) open_r <= '0;
                else            open_r[bank_i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/ready push and valid/yumi pop.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] nxt(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt_r != cnt_w_lp'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push) wptr_r <= nxt(wptr_r);
            if (pop)  rptr_r <= nxt(rptr_r);
            cnt_r <= cnt_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
        end
    end

endmodule

// File: rtl/bsg_dfi_cmd_decoder.sv
// Decodes DFI DDR3 commands into off-chip read/write requests and
// buffers returned read beats, with credit-based read admission.
module bsg_dfi_cmd_decoder
    import bsg_dfi_pkg::*;
#(
    parameter int dq_data_width_p = 32,
    parameter int burst_beats_p   = 4,
    parameter int rd_fifo_els_p   = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_v_i,
    input  logic [25:0]                  cmd_data_i,
    output logic                         cmd_ready_o,
    input  logic                         wr_v_i,
    input  logic [2*dq_data_width_p+dq_data_width_p/4-1:0] wr_data_i,
    output logic                         wr_ready_o,
    output logic                         rd_v_o,
    output logic [2*dq_data_width_p-1:0] rd_data_o,
    input  logic                         rd_yumi_i,
    output logic                         mem_req_v_o,
    output logic [30+2*dq_data_width_p+dq_data_width_p/4-1:0] mem_req_o,
    input  logic                         mem_req_ready_i,
    input  logic                         mem_resp_v_i,
    input  logic [2*dq_data_width_p-1:0] mem_resp_data_i,
    output logic                         error_o
);
    localparam int beat_w_lp = 2*dq_data_width_p + dq_data_width_p/4;
    localparam int bc_w_lp   = (burst_beats_p > 1) ? $clog2(burst_beats_p) : 1;
    localparam int cred_w_lp = $clog2(rd_fifo_els_p + 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BEAT} state_e;

    state_e               state_r;
    logic [1:0]           rst_sync_r;
    logic                 rst_n;
    logic [2:0]           bank_r;
    logic [15:0]          row_r;
    logic [9:0]           col_r;
    logic [bc_w_lp-1:0]   beat_cnt_r;
    logic [cred_w_lp-1:0] credits_r;
    logic                 error_r;

    bsg_dfi_cmd_s     cmd;
    bsg_ddr_cmd_e     ddr_cmd;
    bsg_dfi_mem_hdr_s hdr;
    logic             cmd_fire, rd_block, is_access, in_wr;
    logic             rd_launch, req_fire, rd_pop;
    logic             trk_err, push_err, pop_err, fifo_ready;
    logic [15:0]      trk_row;
    logic             unused_cmd_bits;

    // Async assert, synchronous release for everything downstream
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_r <= '0;
        else            rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
    assign rst_n = rst_sync_r[1];

    assign cmd             = cmd_data_i;
    assign ddr_cmd         = bsg_ddr_decode({cmd.cs_n, cmd.ras_n,
                                             cmd.cas_n, cmd.we_n});
    assign unused_cmd_bits = &{1'b0, cmd.cke, cmd.reset_n, cmd.odt};

    assign in_wr     = (state_r == WR_BEAT);
    assign is_access = (ddr_cmd == RD) | (ddr_cmd == WR);
    assign rd_block  = (ddr_cmd == RD)
                     & (credits_r < cred_w_lp'(burst_beats_p));
    assign cmd_ready_o = rst_n & (state_r == IDLE) & ~rd_block;
    assign cmd_fire    = cmd_v_i & cmd_ready_o;

    assign wr_ready_o  = in_wr & mem_req_ready_i;
    assign mem_req_v_o = (state_r == RD_ISSUE) | (in_wr & wr_v_i);
    assign req_fire    = mem_req_v_o & mem_req_ready_i;
    assign rd_launch   = (state_r == RD_ISSUE) & mem_req_ready_i;

    always_comb begin
        hdr.we   = in_wr;
        hdr.bank = bank_r;
        hdr.row  = row_r;
        hdr.col  = in_wr ? col_r + 10'({beat_cnt_r, 1'b0}) : col_r;
    end
    assign mem_req_o = {hdr, in_wr ? wr_data_i : beat_w_lp'(0)};

    bsg_dfi_bank_tracker u_banks (
        .clk_i     (clk_i),
        .reset_n_i (rst_n),
        .v_i       (cmd_fire),
        .cmd_i     (ddr_cmd),
        .bank_i    (cmd.bank),
        .addr_i    (cmd.addr),
        .row_o     (trk_row),
        .err_o     (trk_err)
    );

    bsg_fifo_1r1w_small #(
        .width_p (2*dq_data_width_p),
        .els_p   (rd_fifo_els_p)
    ) u_rd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (rst_n),
        .v_i       (mem_resp_v_i),
        .data_i    (mem_resp_data_i),
        .ready_o   (fifo_ready),
        .v_o       (rd_v_o),
        .data_o    (rd_data_o),
        .yumi_i    (rd_pop)
    );

    assign rd_pop   = rd_yumi_i & rd_v_o;
    assign pop_err  = rd_yumi_i & ~rd_v_o;
    assign push_err = mem_resp_v_i & ~fifo_ready;
    assign error_o  = error_r;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bank_r     <= '0;
            row_r      <= '0;
            col_r      <= '0;
            beat_cnt_r <= '0;
            credits_r  <= cred_w_lp'(rd_fifo_els_p);
            error_r    <= 1'b0;
        end else begin
            credits_r <= credits_r + cred_w_lp'(rd_pop)
                       - (rd_launch ? cred_w_lp'(burst_beats_p) : '0);
            if (trk_err | push_err | pop_err) error_r <= 1'b1;
            unique case (state_r)
                IDLE: begin
                    if (cmd_fire & is_access) begin
                        bank_r     <= cmd.bank;
                        row_r      <= trk_row;
                        col_r      <= cmd.addr[9:0];
                        beat_cnt_r <= '0;
                        state_r    <= (ddr_cmd == RD) ? RD_ISSUE : WR_BEAT;
                    end
                end
                RD_ISSUE: begin
                    if (mem_req_ready_i) state_r <= IDLE;
                end
                WR_BEAT: begin
                    if (req_fire) begin
                        beat_cnt_r <= beat_cnt_r + 1'b1;
                        if (beat_cnt_r == bc_w_lp'(burst_beats_p - 1))
                            state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
